vga_timing_config: RTL

Multi-profile VGA timing configuration bank with frame-synchronous commit. Host writes timing fields for up to NUM_PROFILES video modes over a Valid/Addr/Data port, then selects a profile. The selected profile is snapshotted and its totals computed at the next frame boundary. Sits between the host/control interface and the VGA sync generator, which consumes the registered timing outputs and `Load_config`.

---
 rtl/vga_cfg_pkg.sv | 47 ++++
 rtl/vga_timing_config_if.sv | 38 +++
 rtl/vga_cfg_profile_store.sv | 88 ++++++++
 rtl/vga_timing_config.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cfg_pkg.sv
// rtl/vga_cfg_pkg.sv - field indices, FSM encoding and 640x480 defaults for vga_timing_config
package vga_cfg_pkg;

  localparam logic [3:0] FLD_HFP    = 4'd0;
  localparam logic [3:0] FLD_HSYNC  = 4'd1;
  localparam logic [3:0] FLD_HBP    = 4'd2;
  localparam logic [3:0] FLD_HACT   = 4'd3;
  localparam logic [3:0] FLD_VFP    = 4'd4;
  localparam logic [3:0] FLD_VSYNC  = 4'd5;
  localparam logic [3:0] FLD_VBP    = 4'd6;
  localparam logic [3:0] FLD_VACT   = 4'd7;
  localparam logic [3:0] FLD_SELECT = 4'd8;

  // Porch slots inside a profile: 0 HFP, 1 HSYNC, 2 HBP, 3 VFP, 4 VSYNC, 5 VBP
  localparam int NUM_PORCH = 6;
  // Resolution slots inside a profile: 0 HACT, 1 VACT
  localparam int NUM_REZ   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_SNAP  = 2'd2,
    ST_APPLY = 2'd3
  } cfg_state_e;

  localparam int DEF_HFP   = 16;
  localparam int DEF_HSYNC = 96;
  localparam int DEF_HBP   = 48;
  localparam int DEF_HACT  = 640;
  localparam int DEF_VFP   = 10;
  localparam int DEF_VSYNC = 2;
  localparam int DEF_VBP   = 33;
  localparam int DEF_VACT  = 480;
  localparam int DEF_HMAX  = 799;
  localparam int DEF_VMAX  = 524;

  // Maps a porch field index onto its slot; HACT/VACT never reach here.
  function automatic logic [2:0] porch_slot(logic [3:0] fld);
    logic [2:0] slot;
    slot = fld[2:0];
    if (fld > FLD_HACT) begin
      slot = fld[2:0] - 3'd1;
    end
    return slot;
  endfunction

endpackage

// File: rtl/vga_timing_config_if.sv
// rtl/vga_timing_config_if.sv - host write/readback port; readback signals under VGA_CFG_READBACK_EN
interface vga_timing_config_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 12
);
  logic                  Valid;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] Data;
`ifdef VGA_CFG_READBACK_EN
  logic                  Rd_en;
  logic [DATA_WIDTH-1:0] Rd_data;
  logic                  Rd_valid;
`endif

  modport master (
    output Valid,
    output Addr,
    output Data
`ifdef VGA_CFG_READBACK_EN
    ,
    output Rd_en,
    input  Rd_data,
    input  Rd_valid
`endif
  );

  modport slave (
    input  Valid,
    input  Addr,
    input  Data
`ifdef VGA_CFG_READBACK_EN
    ,
    input  Rd_en,
    output Rd_data,
    output Rd_valid
`endif
  );
endinterface

// File: rtl/vga_cfg_profile_store.sv
// rtl/vga_cfg_profile_store.sv - per-profile timing field registers; second read port under VGA_CFG_READBACK_EN
module vga_cfg_profile_store
  import vga_cfg_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  parameter int PORCH_WIDTH  = 8,
  parameter int REZ_WIDTH    = 11,
  parameter int PW           = $clog2(NUM_PROFILES)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   wr_en,
  input  logic [PW-1:0]          wr_prof,
  input  logic [3:0]             wr_field,
  input  logic [REZ_WIDTH-1:0]   wr_data,
  input  logic [PW-1:0]          snap_prof,
  output logic [PORCH_WIDTH-1:0] snap_porch [NUM_PORCH],
  output logic [REZ_WIDTH-1:0]   snap_rez   [NUM_REZ]
`ifdef VGA_CFG_READBACK_EN
  ,
  input  logic [PW-1:0]          rb_prof,
  output logic [PORCH_WIDTH-1:0] rb_porch [NUM_PORCH],
  output logic [REZ_WIDTH-1:0]   rb_rez   [NUM_REZ]
`endif
);

  logic [PORCH_WIDTH-1:0] porch_q [NUM_PROFILES][NUM_PORCH];
  logic [PORCH_WIDTH-1:0] porch_d [NUM_PROFILES][NUM_PORCH];
  logic [REZ_WIDTH-1:0]   rez_q   [NUM_PROFILES][NUM_REZ];
  logic [REZ_WIDTH-1:0]   rez_d   [NUM_PROFILES][NUM_REZ];

  // Single write port: only the addressed field of the addressed profile changes
  always_comb begin
    porch_d = porch_q;
    rez_d   = rez_q;
    if (wr_en) begin
      if (wr_field == FLD_HACT) begin
        rez_d[wr_prof][0] = wr_data;
      end else if (wr_field == FLD_VACT) begin
        rez_d[wr_prof][1] = wr_data;
      end else begin
        porch_d[wr_prof][porch_slot(wr_field)] = wr_data[PORCH_WIDTH-1:0];
      end
    end
  end

  // Field registers; every profile comes out of reset as 640x480
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int p = 0; p < NUM_PROFILES; p++) begin
        porch_q[p][0] <= PORCH_WIDTH'(DEF_HFP);
        porch_q[p][1] <= PORCH_WIDTH'(DEF_HSYNC);
        porch_q[p][2] <= PORCH_WIDTH'(DEF_HBP);
        porch_q[p][3] <= PORCH_WIDTH'(DEF_VFP);
        porch_q[p][4] <= PORCH_WIDTH'(DEF_VSYNC);
        porch_q[p][5] <= PORCH_WIDTH'(DEF_VBP);
        rez_q[p][0]   <= REZ_WIDTH'(DEF_HACT);
        rez_q[p][1]   <= REZ_WIDTH'(DEF_VACT);
      end
    end else begin
      porch_q <= porch_d;
      rez_q   <= rez_d;
    end
  end

  // Full-profile read of the profile being committed
  always_comb begin
    for (int s = 0; s < NUM_PORCH; s++) begin
      snap_porch[s] = porch_q[snap_prof][s];
    end
    for (int s = 0; s < NUM_REZ; s++) begin
      snap_rez[s] = rez_q[snap_prof][s];
    end
  end

`ifdef VGA_CFG_READBACK_EN
  // Independent full-profile read for host readback
  always_comb begin
    for (int s = 0; s < NUM_PORCH; s++) begin
      rb_porch[s] = porch_q[rb_prof][s];
    end
    for (int s = 0; s < NUM_REZ; s++) begin
      rb_rez[s] = rez_q[rb_prof][s];
    end
  end
`endif

endmodule

// File: rtl/vga_timing_config.sv
// rtl/vga_timing_config.sv - multi-profile VGA timing bank with frame-synchronous commit; optional readback via VGA_CFG_READBACK_EN
module vga_timing_config
  import vga_cfg_pkg::*;
#(
  parameter int NUM_PROFILES  = 4,
  parameter int PORCH_WIDTH   = 8,
  parameter int REZ_WIDTH     = 11,
  parameter int REZ_MAX_WIDTH = 12,
  parameter int DATA_WIDTH    = 12,
  parameter int ADDR_WIDTH    = $clog2(NUM_PROFILES) + 4
) (
  input  logic                            Clk,
  input  logic                            Rst,
  vga_timing_config_if.slave              host,
  input  logic                            Frame_end,
  output logic                            Pending,
  output logic                            Load_config,
  output logic                            Cfg_error,
  output logic [$clog2(NUM_PROFILES)-1:0] Active_profile,
  output logic [PORCH_WIDTH-1:0]          H_front_porch,
  output logic [PORCH_WIDTH-1:0]          H_sync_width,
  output logic [PORCH_WIDTH-1:0]          H_back_porch,
  output logic [PORCH_WIDTH-1:0]          V_front_porch,
  output logic [PORCH_WIDTH-1:0]          V_sync_width,
  output logic [PORCH_WIDTH-1:0]          V_back_porch,
  output logic [REZ_WIDTH-1:0]            H_count_activ,
  output logic [REZ_WIDTH-1:0]            V_count_activ,
  output logic [REZ_MAX_WIDTH-1:0]        H_count_max,
  output logic [REZ_MAX_WIDTH-1:0]        V_count_max
);

  localparam int PW = $clog2(NUM_PROFILES);
  // One extra bit so an oversized total is detectable rather than wrapping
  localparam int TW = REZ_MAX_WIDTH + 1;

  logic [3:0]    field;
  logic [PW-1:0] wr_prof;
  logic          is_select;
  logic          is_field_wr;
  logic          unused_data;

  assign field       = host.Addr[3:0];
  assign wr_prof     = host.Addr[ADDR_WIDTH-1:4];
  assign is_select   = host.Valid && (field == FLD_SELECT);
  assign is_field_wr = host.Valid && (field < FLD_SELECT);
  assign unused_data = ^host.Data;

  cfg_state_e             state_q, state_d;
  logic [PW-1:0]          sel_idx_q, sel_idx_d;
  logic                   resel_q, resel_d;
  logic [PW-1:0]          stg_idx_q, stg_idx_d;
  logic [PORCH_WIDTH-1:0] stg_porch_q [NUM_PORCH];
  logic [PORCH_WIDTH-1:0] stg_porch_d [NUM_PORCH];
  logic [REZ_WIDTH-1:0]   stg_rez_q   [NUM_REZ];
  logic [REZ_WIDTH-1:0]   stg_rez_d   [NUM_REZ];
  logic [TW-1:0]          h_total_q, h_total_d;
  logic [TW-1:0]          v_total_q, v_total_d;
  logic [PORCH_WIDTH-1:0] out_porch_q [NUM_PORCH];
  logic [PORCH_WIDTH-1:0] out_porch_d [NUM_PORCH];
  logic [REZ_WIDTH-1:0]   out_hact_q, out_hact_d;
  logic [REZ_WIDTH-1:0]   out_vact_q, out_vact_d;
  logic [REZ_MAX_WIDTH-1:0] hmax_q, hmax_d;
  logic [REZ_MAX_WIDTH-1:0] vmax_q, vmax_d;
  logic [PW-1:0]          active_q, active_d;
  logic                   load_q, load_d;
  logic                   err_q, err_d;
  logic                   h_ok, v_ok;

  logic [PORCH_WIDTH-1:0] snap_porch [NUM_PORCH];
  logic [REZ_WIDTH-1:0]   snap_rez   [NUM_REZ];

`ifdef VGA_CFG_READBACK_EN
  logic [PORCH_WIDTH-1:0] rb_porch [NUM_PORCH];
  logic [REZ_WIDTH-1:0]   rb_rez   [NUM_REZ];
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
`endif

  vga_cfg_profile_store #(
    .NUM_PROFILES (NUM_PROFILES),
    .PORCH_WIDTH  (PORCH_WIDTH),
    .REZ_WIDTH    (REZ_WIDTH),
    .PW           (PW)
  ) u_store (
    .Clk        (Clk),
    .Rst        (Rst),
    .wr_en      (is_field_wr),
    .wr_prof    (wr_prof),
    .wr_field   (field),
    .wr_data    (host.Data[REZ_WIDTH-1:0]),
    .snap_prof  (sel_idx_q),
    .snap_porch (snap_porch),
    .snap_rez   (snap_rez)
`ifdef VGA_CFG_READBACK_EN
    ,
    .rb_prof    (wr_prof),
    .rb_porch   (rb_porch),
    .rb_rez     (rb_rez)
`endif
  );

  // A total is usable only if it fits the counter and is not empty
  assign h_ok = !h_total_q[REZ_MAX_WIDTH] && (h_total_q != '0);
  assign v_ok = !v_total_q[REZ_MAX_WIDTH] && (v_total_q != '0);

  // Commit FSM: latch selection, snapshot on frame end, sum, then apply or reject
  always_comb begin
    state_d     = state_q;
    sel_idx_d   = sel_idx_q;
    resel_d     = resel_q;
    stg_idx_d   = stg_idx_q;
    stg_porch_d = stg_porch_q;
    stg_rez_d   = stg_rez_q;
    h_total_d   = h_total_q;
    v_total_d   = v_total_q;
    out_porch_d = out_porch_q;
    out_hact_d  = out_hact_q;
    out_vact_d  = out_vact_q;
    hmax_d      = hmax_q;
    vmax_d      = vmax_q;
    active_d    = active_q;
    load_d      = 1'b0;
    err_d       = 1'b0;

    if (is_select) begin
      sel_idx_d = host.Data[PW-1:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (is_select) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (Frame_end) begin
          state_d     = ST_SNAP;
          stg_idx_d   = sel_idx_q;
          stg_porch_d = snap_porch;
          stg_rez_d   = snap_rez;
          // A SELECT landing on the snapshot edge is for the next commit
          resel_d     = is_select;
        end
      end
      ST_SNAP: begin
        state_d   = ST_APPLY;
        h_total_d = TW'(stg_rez_q[0]) + TW'(stg_porch_q[0])
                  + TW'(stg_porch_q[1]) + TW'(stg_porch_q[2]);
        v_total_d = TW'(stg_rez_q[1]) + TW'(stg_porch_q[3])
                  + TW'(stg_porch_q[4]) + TW'(stg_porch_q[5]);
        if (is_select) begin
          resel_d = 1'b1;
        end
      end
      ST_APPLY: begin
        if (h_ok && v_ok) begin
          out_porch_d = stg_porch_q;
          out_hact_d  = stg_rez_q[0];
          out_vact_d  = stg_rez_q[1];
          hmax_d      = h_total_q[REZ_MAX_WIDTH-1:0] - REZ_MAX_WIDTH'(1);
          vmax_d      = v_total_q[REZ_MAX_WIDTH-1:0] - REZ_MAX_WIDTH'(1);
          active_d    = stg_idx_q;
          load_d      = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = (resel_q || is_select) ? ST_PEND : ST_IDLE;
        resel_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, staging and output registers; reset restores 640x480 and drops any commit
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= ST_IDLE;
      sel_idx_q      <= '0;
      resel_q        <= 1'b0;
      stg_idx_q      <= '0;
      for (int s = 0; s < NUM_PORCH; s++) begin
        stg_porch_q[s] <= '0;
      end
      for (int s = 0; s < NUM_REZ; s++) begin
        stg_rez_q[s] <= '0;
      end
      h_total_q      <= '0;
      v_total_q      <= '0;
      out_porch_q[0] <= PORCH_WIDTH'(DEF_HFP);
      out_porch_q[1] <= PORCH_WIDTH'(DEF_HSYNC);
      out_porch_q[2] <= PORCH_WIDTH'(DEF_HBP);
      out_porch_q[3] <= PORCH_WIDTH'(DEF_VFP);
      out_porch_q[4] <= PORCH_WIDTH'(DEF_VSYNC);
      out_porch_q[5] <= PORCH_WIDTH'(DEF_VBP);
      out_hact_q     <= REZ_WIDTH'(DEF_HACT);
      out_vact_q     <= REZ_WIDTH'(DEF_VACT);
      hmax_q         <= REZ_MAX_WIDTH'(DEF_HMAX);
      vmax_q         <= REZ_MAX_WIDTH'(DEF_VMAX);
      active_q       <= '0;
      load_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_idx_q   <= sel_idx_d;
      resel_q     <= resel_d;
      stg_idx_q   <= stg_idx_d;
      stg_porch_q <= stg_porch_d;
      stg_rez_q   <= stg_rez_d;
      h_total_q   <= h_total_d;
      v_total_q   <= v_total_d;
      out_porch_q <= out_porch_d;
      out_hact_q  <= out_hact_d;
      out_vact_q  <= out_vact_d;
      hmax_q      <= hmax_d;
      vmax_q      <= vmax_d;
      active_q    <= active_d;
      load_q      <= load_d;
      err_q       <= err_d;
    end
  end

  assign Pending        = (state_q != ST_IDLE);
  assign Load_config    = load_q;
  assign Cfg_error      = err_q;
  assign Active_profile = active_q;
  assign H_front_porch  = out_porch_q[0];
  assign H_sync_width   = out_porch_q[1];
  assign H_back_porch   = out_porch_q[2];
  assign V_front_porch  = out_porch_q[3];
  assign V_sync_width   = out_porch_q[4];
  assign V_back_porch   = out_porch_q[5];
  assign H_count_activ  = out_hact_q;
  assign V_count_activ  = out_vact_q;
  assign H_count_max    = hmax_q;
  assign V_count_max    = vmax_q;

`ifdef VGA_CFG_READBACK_EN
  // Readback mux over current storage, so a same-cycle write returns the old value
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = host.Rd_en;
    if (host.Rd_en) begin
      case (field)
        FLD_HFP:    rd_data_d = DATA_WIDTH'(rb_porch[0]);
        FLD_HSYNC:  rd_data_d = DATA_WIDTH'(rb_porch[1]);
        FLD_HBP:    rd_data_d = DATA_WIDTH'(rb_porch[2]);
        FLD_HACT:   rd_data_d = DATA_WIDTH'(rb_rez[0]);
        FLD_VFP:    rd_data_d = DATA_WIDTH'(rb_porch[3]);
        FLD_VSYNC:  rd_data_d = DATA_WIDTH'(rb_porch[4]);
        FLD_VBP:    rd_data_d = DATA_WIDTH'(rb_porch[5]);
        FLD_VACT:   rd_data_d = DATA_WIDTH'(rb_rez[1]);
        FLD_SELECT: rd_data_d = DATA_WIDTH'(sel_idx_q);
        default:    rd_data_d = '0;
      endcase
    end
  end

  // Readback response registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign host.Rd_data  = rd_data_q;
  assign host.Rd_valid = rd_valid_q;
`endif

endmodule
